// File: rtl/spi_master_if.sv
// Bus interface for spi_master: request/response handshake plus the four SPI pins.
// The master modport is the view the spi_master block takes; the slave modport is
// the view of whatever drives requests and models the SPI device.
interface spi_master_if;
  logic       enviar_dato;
  logic       recibir_dato;
  logic [7:0] din;
  logic [7:0] dout;
  logic       wait_n;
  logic       spi_clk;
  logic       spi_di;
  logic       spi_do;

  modport master (
    input  enviar_dato,
    input  recibir_dato,
    input  din,
    input  spi_do,
    output dout,
    output wait_n,
    output spi_clk,
    output spi_di
  );

  modport slave (
    output enviar_dato,
    output recibir_dato,
    output din,
    output spi_do,
    input  dout,
    input  wait_n,
    input  spi_clk,
    input  spi_di
  );
endinterface

// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, MSB first.
// A send request shifts din out on spi_di; a receive request shifts out 0xFF and
// captures spi_do into dout. wait_n is low while a byte is on the wire.
// One byte takes 16*DIV clk cycles (DIV = spi_clk half-period, 1..255).
// Optional feature macro: SPI_CAPTURE_ON_SEND_EN -- when defined, send transfers are
// full duplex and also write the bits sampled on spi_do into dout.
module spi_master #(
  parameter int unsigned DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } state_t;

`ifdef SPI_CAPTURE_ON_SEND_EN
  localparam bit CaptureOnSend = 1'b1;
`else
  localparam bit CaptureOnSend = 1'b0;
`endif

  localparam logic [7:0] TimerLast = 8'(DIV - 1);

  state_t     state_q,   state_d;
  logic [7:0] timer_q,   timer_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  // A single register carries the outgoing byte out of bit 7 and collects the
  // incoming bits at bit 0, so after eight shifts it holds the received byte.
  logic [7:0] shreg_q,   shreg_d;
  logic       recv_q,    recv_d;
  logic [7:0] dout_q,    dout_d;
  logic       wait_n_q,  wait_n_d;
  logic       spi_clk_q, spi_clk_d;
  logic       spi_di_q,  spi_di_d;

  logic phase_done;
  assign phase_done = (timer_q == TimerLast);

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every signal gets a hold default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    recv_d    = recv_q;
    dout_d    = dout_q;
    wait_n_d  = wait_n_q;
    spi_clk_d = spi_clk_q;
    spi_di_d  = spi_di_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enviar_dato || bus.recibir_dato) begin
          // Send wins when both requests arrive together.
          if (bus.enviar_dato) begin
            shreg_d  = bus.din;
            recv_d   = 1'b0;
            spi_di_d = bus.din[7];
          end else begin
            shreg_d  = 8'hFF;
            recv_d   = 1'b1;
            spi_di_d = 1'b1;
          end
          wait_n_d  = 1'b0;
          timer_d   = 8'd0;
          bit_cnt_d = 3'd0;
          state_d   = LOW;
        end
      end

      LOW: begin
        if (phase_done) begin
          // Rising spi_clk: the slave's bit is sampled here (mode 0).
          timer_d   = 8'd0;
          spi_clk_d = 1'b1;
          shreg_d   = {shreg_q[6:0], bus.spi_do};
          state_d   = HIGH;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      HIGH: begin
        if (phase_done) begin
          timer_d   = 8'd0;
          spi_clk_d = 1'b0;
          if (bit_cnt_q == 3'd7) begin
            wait_n_d  = 1'b1;
            spi_di_d  = 1'b1;
            bit_cnt_d = 3'd0;
            state_d   = IDLE;
            if (recv_q || CaptureOnSend) begin
              dout_d = shreg_q;
            end
          end else begin
            // Falling spi_clk: present the next outgoing bit.
            bit_cnt_d = bit_cnt_q + 3'd1;
            spi_di_d  = shreg_q[7];
            state_d   = LOW;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset; reset aborts any transfer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'hFF;
      recv_q    <= 1'b0;
      dout_q    <= 8'hFF;
      wait_n_q  <= 1'b1;
      spi_clk_q <= 1'b0;
      spi_di_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      recv_q    <= recv_d;
      dout_q    <= dout_d;
      wait_n_q  <= wait_n_d;
      spi_clk_q <= spi_clk_d;
      spi_di_q  <= spi_di_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.wait_n  = wait_n_q;
  assign bus.spi_clk = spi_clk_q;
  assign bus.spi_di  = spi_di_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: one DIV=1 and one DIV=3 instance share the
// stimulus; a select picks which one receives requests and is observed.
// Expected behaviour comes from a transfer-level model: bit order, cycle counts,
// phase lengths and the dout value each byte should leave behind.
module tb_spi_master;

`ifdef SPI_CAPTURE_ON_SEND_EN
  localparam bit CAPTURE = 1'b1;
`else
  localparam bit CAPTURE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus driven by the tests.
  int         sel = 0;
  logic       req_send = 1'b0;
  logic       req_recv = 1'b0;
  logic [7:0] din_v = 8'h00;

  // Slave model: presents slave_byte MSB first, advancing on each falling spi_clk.
  logic [7:0] slave_byte = 8'hFF;
  int         fall_count = 0;
  int         slave_base = 0;
  int         slave_pos;
  logic       spi_do_w;

  logic [7:0] exp_dout [2];

  spi_master_if if1 ();
  spi_master_if if3 ();

  spi_master #(.DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  spi_master #(.DIV(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));

  assign if1.enviar_dato  = (sel == 0) && req_send;
  assign if1.recibir_dato = (sel == 0) && req_recv;
  assign if3.enviar_dato  = (sel != 0) && req_send;
  assign if3.recibir_dato = (sel != 0) && req_recv;
  assign if1.din    = din_v;
  assign if3.din    = din_v;
  assign if1.spi_do = spi_do_w;
  assign if3.spi_do = spi_do_w;

  logic       obs_clk, obs_di, obs_wait_n;
  logic [7:0] obs_dout;
  assign obs_clk    = (sel != 0) ? if3.spi_clk : if1.spi_clk;
  assign obs_di     = (sel != 0) ? if3.spi_di  : if1.spi_di;
  assign obs_wait_n = (sel != 0) ? if3.wait_n  : if1.wait_n;
  assign obs_dout   = (sel != 0) ? if3.dout    : if1.dout;

  always @(negedge obs_clk) fall_count = fall_count + 1;

  assign slave_pos = fall_count - slave_base;
  assign spi_do_w  = (slave_pos >= 0 && slave_pos < 8) ? slave_byte[3'(7 - slave_pos)] : 1'b1;

  // One complete transfer on the selected instance, checked against the model.
  task automatic do_xfer(input string name, input bit snd, input bit rcv,
                         input logic [7:0] d, input logic [7:0] sb, input bit busy_req);
    int div, low_cnt, rises, run, nruns, bad_runs;
    logic prev_clk;
    logic [7:0] got_bits, exp_bits, exp_d;
    div = (sel != 0) ? 3 : 1;
    exp_bits = snd ? d : 8'hFF;
    exp_d = exp_dout[sel];
    if (snd ? CAPTURE : rcv) exp_d = sb;

    slave_byte = sb;
    slave_base = fall_count;
    req_send = snd;
    req_recv = rcv;
    din_v = d;
    @(negedge clk);
    req_send = 1'b0;
    req_recv = 1'b0;
    din_v = ~d;

    low_cnt = 0; rises = 0; run = 0; nruns = 0; bad_runs = 0;
    prev_clk = 1'b0; got_bits = 8'h00;
    while (obs_wait_n === 1'b0 && low_cnt < 16 * div + 8) begin
      low_cnt++;
      if (low_cnt > 1 && obs_clk !== prev_clk) begin
        nruns++;
        if (run != div) bad_runs++;
        run = 0;
      end
      run++;
      if (obs_clk === 1'b1 && prev_clk === 1'b0) begin
        if (rises < 8) got_bits = {got_bits[6:0], obs_di};
        rises++;
      end
      prev_clk = obs_clk;
      if (busy_req && low_cnt == 5) begin
        req_send = 1'b1;
        req_recv = 1'b1;
        din_v = 8'h00;
      end else begin
        req_send = 1'b0;
        req_recv = 1'b0;
      end
      @(negedge clk);
    end
    if (run > 0) begin
      nruns++;
      if (run != div) bad_runs++;
    end

    checks++;
    if (low_cnt !== 16 * div) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected %0d", name, low_cnt, 16 * div);
    end
    checks++;
    if (rises !== 8) begin
      errors++;
      $display("FAIL %s_rising_edges: got %0d expected 8", name, rises);
    end
    checks++;
    if (got_bits !== exp_bits) begin
      errors++;
      $display("FAIL %s_mosi_bits: got %h expected %h", name, got_bits, exp_bits);
    end
    checks++;
    if (nruns !== 16 || bad_runs !== 0) begin
      errors++;
      $display("FAIL %s_phases: got %0d phases (%0d wrong length) expected 16 of %0d cycles",
               name, nruns, bad_runs, div);
    end
    checks++;
    if (obs_di !== 1'b1 || obs_clk !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_pins: got spi_di=%b spi_clk=%b expected 1 0", name, obs_di, obs_clk);
    end
    checks++;
    if (obs_dout !== exp_d) begin
      errors++;
      $display("FAIL %s_dout: got %h expected %h", name, obs_dout, exp_d);
    end
    exp_dout[sel] = exp_d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_send = 1'b0;
    req_recv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_dout[0] = 8'hFF;
    exp_dout[1] = 8'hFF;
    checks++;
    if (if1.spi_clk !== 1'b0 || if1.spi_di !== 1'b1 || if1.wait_n !== 1'b1 || if1.dout !== 8'hFF) begin
      errors++;
      $display("FAIL reset_div1: got clk=%b di=%b wait_n=%b dout=%h expected 0 1 1 ff",
               if1.spi_clk, if1.spi_di, if1.wait_n, if1.dout);
    end
    checks++;
    if (if3.spi_clk !== 1'b0 || if3.spi_di !== 1'b1 || if3.wait_n !== 1'b1 || if3.dout !== 8'hFF) begin
      errors++;
      $display("FAIL reset_div3: got clk=%b di=%b wait_n=%b dout=%h expected 0 1 1 ff",
               if3.spi_clk, if3.spi_di, if3.wait_n, if3.dout);
    end
  endtask

  task automatic test_send();
    sel = 0;
    do_xfer("send_40", 1'b1, 1'b0, 8'h40, 8'h5A, 1'b0);
  endtask

  task automatic test_receive();
    sel = 0;
    do_xfer("recv_01", 1'b0, 1'b1, 8'h5A, 8'h01, 1'b0);
  endtask

  task automatic test_priority();
    sel = 0;
    do_xfer("both_95", 1'b1, 1'b1, 8'h95, 8'h3C, 1'b0);
  endtask

  task automatic test_busy_ignore();
    sel = 0;
    do_xfer("busy_req", 1'b0, 1'b1, 8'hC3, 8'hA7, 1'b1);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    do_xfer("recv_ff", 1'b0, 1'b1, 8'h00, 8'hFF, 1'b0);
    slave_byte = 8'h3C;
    slave_base = fall_count;
    req_recv = 1'b1;
    @(negedge clk);
    req_recv = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dout[0] = 8'hFF;
    exp_dout[1] = 8'hFF;
    checks++;
    if (obs_wait_n !== 1'b1 || obs_clk !== 1'b0 || obs_di !== 1'b1 || obs_dout !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid: got wait_n=%b clk=%b di=%b dout=%h expected 1 0 1 ff",
               obs_wait_n, obs_clk, obs_di, obs_dout);
    end
    do_xfer("after_reset", 1'b1, 1'b0, 8'hA5, 8'h96, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n, rises;
    logic prev;
    logic [7:0] b, bits, exp_d;
    sel = 0;
    b = 8'($urandom);
    slave_byte = 8'hFF;
    slave_base = fall_count;
    exp_d = CAPTURE ? 8'hFF : exp_dout[0];
    req_send = 1'b1;
    din_v = 8'hC5;
    @(negedge clk);
    din_v = b;
    n = 0;
    while (obs_wait_n === 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL b2b_first_busy: got %0d expected 16", n);
    end
    n = 0;
    while (obs_wait_n === 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    req_send = 1'b0;
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL b2b_idle_gap: got %0d expected 1", n);
    end
    n = 0; rises = 0; prev = 1'b0; bits = 8'h00;
    while (obs_wait_n === 1'b0 && n < 40) begin
      n++;
      if (obs_clk === 1'b1 && prev === 1'b0) begin
        bits = {bits[6:0], obs_di};
        rises++;
      end
      prev = obs_clk;
      @(negedge clk);
    end
    checks++;
    if (n !== 16 || rises !== 8 || bits !== b) begin
      errors++;
      $display("FAIL b2b_second: got %0d cycles %0d edges bits %h expected 16 8 %h", n, rises, bits, b);
    end
    checks++;
    if (obs_dout !== exp_d) begin
      errors++;
      $display("FAIL b2b_dout: got %h expected %h", obs_dout, exp_d);
    end
    exp_dout[0] = exp_d;
  endtask

  task automatic test_div3();
    sel = 1;
    do_xfer("div3_ff", 1'b1, 1'b0, 8'hFF, 8'h81, 1'b0);
    do_xfer("div3_recv", 1'b0, 1'b1, 8'h00, 8'h6D, 1'b0);
    sel = 0;
  endtask

  task automatic test_random();
    int mode;
    for (int i = 0; i < 20; i++) begin
      sel = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      do_xfer("random", mode != 1, mode != 0, 8'($urandom), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_send();
    test_receive();
    test_priority();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_div3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
